delay_pipe_sched: RTL and testbench
===================================

# delay_pipe_sched

Shares one fixed-latency delay datapath among R requesters. Each cycle a round-robin arbiter grants at most one request. The granted payload and its requester ID travel through an internal N-stage pipeline, and the result is returned to the originating requester exactly N cycles later. Optional per-requester credit counters cap outstanding work so requesters can size their response sinks.

## Interface
- `R`, default 4: number of requesters; must be ≥2.
- `N`, default 5: pipeline latency in cycles; must be ≥1.
- `W`, default 32: payload width.
- `C`, default 2: credits per requester, 1..N; used only with `DELAY_PIPE_SCHED_CREDIT_EN`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_vld` in R: request valid per requester.
- `req_dat` in R*W: requester i payload at bits [i*W +: W].
- `req_ack` out R: one-hot-or-zero grant, combinational in the same cycle; the request is consumed when `req_vld[i] & req_ack[i]`.
- `rsp_vld_r` out R: one-hot-or-zero response valid, registered.
- `rsp_dat_r` out W: response payload, shared by all requesters, registered.
- `inflight_r` out $clog2(N+1): number of valid pipeline stages.
- `busy` out 1: `inflight_r != 0`.

## Operation
- Eligibility: `elig[i] = req_vld[i]`, AND'd with `credit_r[i] != 0` when credits are enabled.
- Arbiter:
  - Round-robin priority pointer `prio_r` (width $clog2(R)); requester `prio_r` has highest priority, scanning upward with wrap from R-1 to 0.
  - The first eligible requester is acked.
  - On a grant to i: `prio_r <= (i == R-1) ? 0 : i+1`.
  - No grant: `prio_r` holds.
- Pipeline:
  - N stages, each holding {vld, id, dat}, shifting one stage per cycle unconditionally; there is no stall and no backpressure.
  - Stage 0 loads {1, granted id, granted dat} on a grant, else {0, held id, held dat}; data is held to save power.
- Output: `rsp_vld_r[id] <= stage[N-1].vld`. `rsp_dat_r` loads only when `stage[N-1].vld`, and otherwise holds.
- `inflight_r`: +1 on grant and −1 when `stage[N-1].vld` exits; both in the same cycle leave it unchanged.
- Credits (when enabled):
  - `credit_r[i]` has width $clog2(C+1) and resets to C.
  - −1 on grant to i; +1 on `rsp_vld_r[i]` (the response cycle).
  - Both in the same cycle leave it unchanged.
  - It never underflows (gated by eligibility) or exceeds C; exceeding C is a fatal assertion.
- Requesters must accept responses unconditionally.

## Timing
- Reset values:
  - `req_ack` = 0 while in reset (combinational, forced).
  - `rsp_vld_r` = 0, `rsp_dat_r` = 0, `inflight_r` = 0, `busy` = 0.
  - All stage vld = 0, `prio_r` = 0, `credit_r` = C.
- Latency: grant in cycle t gives `rsp_vld_r` high in cycle t+N for exactly one cycle.
- Throughput: one grant per cycle; `inflight_r` maximum is N.
- A deasserted `req_vld` withdraws the request with no penalty, and the pointer does not move.
- A credit returned in cycle t makes the requester eligible in cycle t+1, not in t.
- Reset mid-operation: all in-flight entries are discarded, no responses are produced for them, and credits are restored to C.

## Configuration
- `DELAY_PIPE_SCHED_CREDIT_EN` defined: per-requester credit counters are present and gate eligibility as above.
- Not defined: counters are absent, `elig = req_vld`, parameter C is ignored, and a requester may have up to N entries in flight.

## Test plan
- **Single request:** R=4, N=5; `req_vld` = 4'b0100 with dat 0xA5 in cycle 3 -> `req_ack` = 4'b0100 in cycle 3; `rsp_vld_r` = 4'b0100, `rsp_dat_r` = 0xA5 in cycle 8 only; `inflight_r` reads 1 in cycles 4–8 and 0 in cycle 9.
- **Round-robin fairness:** all four requesting continuously from reset -> grants 0,1,2,3,0,1… with no gaps; responses follow the same order, each N cycles after its grant.
- **Credit exhaustion (macro on, C=2):** only requester 1 holds `req_vld` continuously from cycle 0 -> acks in cycles 0 and 1, none in 2–4, credit returns in cycle 5 (first response), next ack in cycle 6.
- **Macro off:** same stimulus -> acks every cycle 0..N+2; `inflight_r` saturates at 5.
- **Simultaneous grant and return:** requester 0 with C=1 response in cycle t while requester 2 is granted -> `credit_r[0]` becomes 1 and `inflight_r` is unchanged in cycle t+1.
- **Reset mid-flight:** 3 entries in flight, `rst_n` low for 1 cycle -> no `rsp_vld_r` pulses afterwards; `credit_r` all equal C; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/delay_pipe_sched_if.sv
// delay_pipe_sched_if: request/response bundle between the requesters and delay_pipe_sched.
interface delay_pipe_sched_if #(
    parameter int R = 4,
    parameter int N = 5,
    parameter int W = 32
);
    logic [R-1:0]           req_vld;
    logic [R*W-1:0]         req_dat;
    logic [R-1:0]           req_ack;
    logic [R-1:0]           rsp_vld_r;
    logic [W-1:0]           rsp_dat_r;
    logic [$clog2(N+1)-1:0] inflight_r;
    logic                   busy;
    modport master (output req_vld, req_dat, input req_ack, rsp_vld_r, rsp_dat_r, inflight_r, busy);
    modport slave  (input req_vld, req_dat, output req_ack, rsp_vld_r, rsp_dat_r, inflight_r, busy);
endinterface

// File: rtl/delay_pipe_sched.sv
// delay_pipe_sched: round-robin shared N-cycle delay pipe returning results to R requesters.
// Define DELAY_PIPE_SCHED_CREDIT_EN to cap each requester at C outstanding entries.
module delay_pipe_sched #(
    parameter int R = 4,
    parameter int N = 5,
    parameter int W = 32,
    parameter int C = 2
) (
    input logic               clk,
    input logic               rst_n,
    delay_pipe_sched_if.slave pif
);
    localparam int PW = $clog2(R);
    localparam int IW = $clog2(N + 1);

    logic [R-1:0]  elig;
    logic          gnt;
    logic [PW-1:0] gnt_id;
    logic [PW-1:0] j;
    logic [W-1:0]  gnt_dat;
    logic [PW-1:0] prio_q, prio_d;
    logic          lst_vld;
    logic [PW-1:0] lst_id;
    logic [W-1:0]  lst_dat;
    logic [R-1:0]  rsp_vld_q, rsp_vld_d;
    logic [W-1:0]  rsp_dat_q, rsp_dat_d;
    logic [IW-1:0] inflight_q, inflight_d;

    // Scanning downward lets the highest-priority eligible requester win the last write.
    always_comb begin
        gnt     = 1'b0;
        gnt_id  = '0;
        j       = '0;
        gnt_dat = '0;
        for (int k = R - 1; k >= 0; k--) begin
            j = PW'((int'(prio_q) + k) % R);
            if (elig[j]) begin
                gnt    = 1'b1;
                gnt_id = j;
            end
        end
        for (int k = 0; k < R; k++) begin
            if (gnt_id == PW'(k)) gnt_dat = pif.req_dat[k*W +: W];
        end
    end

    assign pif.req_ack = (rst_n && gnt) ? R'(1) << gnt_id : '0;

    // The response registers form the last stage, so stages 0..N-2 live here.
    if (N > 1) begin : g_pipe
        logic [N-2:0]  vld_q;
        logic [PW-1:0] id_q  [N-1];
        logic [W-1:0]  dat_q [N-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int k = 0; k < N - 1; k++) begin
                    id_q[k]  <= '0;
                    dat_q[k] <= '0;
                end
            end else begin
                vld_q[0] <= gnt;
                if (gnt) begin
                    id_q[0]  <= gnt_id;
                    dat_q[0] <= gnt_dat;
                end
                for (int k = 1; k < N - 1; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    id_q[k]  <= id_q[k-1];
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
        assign lst_vld = vld_q[N-2];
        assign lst_id  = id_q[N-2];
        assign lst_dat = dat_q[N-2];
    end else begin : g_direct
        assign lst_vld = gnt;
        assign lst_id  = gnt_id;
        assign lst_dat = gnt_dat;
    end

    always_comb begin
        rsp_vld_d  = lst_vld ? R'(1) << lst_id : '0;
        rsp_dat_d  = lst_vld ? lst_dat : rsp_dat_q;
        inflight_d = inflight_q + IW'(gnt) - IW'(|rsp_vld_q);
        prio_d     = !gnt ? prio_q : (gnt_id == PW'(R - 1)) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= '0;
            rsp_vld_q  <= '0;
            rsp_dat_q  <= '0;
            inflight_q <= '0;
        end else begin
            prio_q     <= prio_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_dat_q  <= rsp_dat_d;
            inflight_q <= inflight_d;
        end
    end

    assign pif.rsp_vld_r  = rsp_vld_q;
    assign pif.rsp_dat_r  = rsp_dat_q;
    assign pif.inflight_r = inflight_q;
    assign pif.busy       = inflight_q != '0;

`ifdef DELAY_PIPE_SCHED_CREDIT_EN
    localparam int CW = $clog2(C + 1);
    logic [CW-1:0] credit_q [R];
    logic [CW-1:0] credit_d [R];
    always_comb begin
        for (int k = 0; k < R; k++) begin
            credit_d[k] = credit_q[k] + CW'(rsp_vld_q[k]) - CW'(gnt && gnt_id == PW'(k));
            elig[k]     = pif.req_vld[k] && credit_q[k] != '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < R; k++) begin
            if (!rst_n) credit_q[k] <= CW'(C);
            else        credit_q[k] <= credit_d[k];
        end
    end
    for (genvar g = 0; g < R; g++) begin : g_credit_chk
        assert property (@(posedge clk) disable iff (!rst_n) credit_q[g] <= CW'(C))
            else $fatal(1, "credit overflow on requester %0d", g);
    end
`else
    assign elig = pif.req_vld;
`endif

    // Misconfigured parameters trip on the first clock instead of silently misbehaving.
    if (R < 2 || N < 1 || C < 1 || C > N) begin : g_bad_cfg
        assert property (@(posedge clk) 1'b0) else $fatal(1, "bad delay_pipe_sched parameters");
    end
endmodule

// File: tb/tb_delay_pipe_sched.sv
// tb_delay_pipe_sched: randomized bench against a queue-based response-schedule model.
module tb_delay_pipe_sched;
    localparam int R  = 4;
    localparam int N  = 5;
    localparam int W  = 32;
    localparam int C  = 2;
    localparam int IW = $clog2(N + 1);
    localparam int VW = 2 * R + W + 1 + IW;
`ifdef DELAY_PIPE_SCHED_CREDIT_EN
    localparam bit CREDIT = 1'b1;
`else
    localparam bit CREDIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    delay_pipe_sched_if #(.R(R), .N(N), .W(W)) bus ();
    delay_pipe_sched #(.R(R), .N(N), .W(W), .C(C)) dut (.clk(clk), .rst_n(rst_n), .pif(bus));

    // Every accepted request is a scheduled response due exactly N cycles after its grant.
    typedef struct { int due; int id; logic [W-1:0] dat; } ent_t;
    ent_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc, m_prio;
    logic [W-1:0] m_last;
    logic [R-1:0] exp_ack, exp_rsp;
    logic [W-1:0] exp_dat;
    int exp_infl;

    function automatic logic [R*W-1:0] rand_dat();
        logic [R*W-1:0] d;
        for (int k = 0; k < R; k++) d[k*W +: W] = W'($urandom);
        return d;
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.req_ack, bus.rsp_vld_r, bus.rsp_dat_r, bus.busy, bus.inflight_r};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {exp_ack, exp_rsp, exp_dat, exp_infl != 0, IW'(exp_infl)};
    endfunction

    task automatic model_step();
        int pick, r, n;
        ent_t e;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        exp_infl = q.size();
        exp_rsp  = '0;
        exp_dat  = m_last;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rsp[q[0].id] = 1'b1;
            exp_dat = q[0].dat;
        end
        exp_ack = '0;
        pick = -1;
        for (int k = 0; k < R; k++) begin
            r = (m_prio + k) % R;
            n = 0;
            foreach (q[i]) if (q[i].id == r) n++;
            if (pick < 0 && bus.req_vld[r] && (!CREDIT || n < C)) pick = r;
        end
        if (pick >= 0) begin
            exp_ack[pick] = 1'b1;
            e.due = cyc + N;
            e.id  = pick;
            e.dat = bus.req_dat[pick*W +: W];
            q.push_back(e);
            m_prio = (pick + 1) % R;
        end
        if (exp_rsp != '0) m_last = exp_dat;
        cyc++;
    endtask

    task automatic model_reset();
        q.delete();
        m_prio = 0;
        m_last = '0;
        cyc = 0;
    endtask

    task automatic drive_step(input logic [R-1:0] v, input logic [R*W-1:0] d);
        bus.req_vld = v;
        bus.req_dat = d;
        #4;
        model_step();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_vld = '0;
        bus.req_dat = '0;
        rst_n = 1'b0;
        next();
        next();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_vld = '1;
        bus.req_dat = rand_dat();
        next();
        #3;
        checks++;
        if ({bus.req_ack, bus.rsp_vld_r, bus.rsp_dat_r, bus.busy, bus.inflight_r} !== '0)
            begin failures++; $display("FAIL reset_outputs got=%h exp=0", dut_vec()); end
        next();
        rst_n = 1'b1;
        model_reset();
        drive_step('1, rand_dat());
        checks++;
        if (bus.req_ack !== 4'b0001) begin failures++; $display("FAIL reset_first_ack got=%b exp=0001", bus.req_ack); end
        checks++;
        if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc - 1, dut_vec(), exp_vec()); end
        next();
    endtask

    task automatic test_single();
        logic [R*W-1:0] d;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            d = rand_dat();
            d[2*W +: W] = W'(32'hA5);
            drive_step(c == 3 ? 4'b0100 : 4'b0000, d);
            checks++;
            if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL single_model cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
            checks++;
            if (bus.req_ack !== (c == 3 ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL single_ack cyc=%0d got=%b", c, bus.req_ack); end
            checks++;
            if (bus.rsp_vld_r !== (c == 8 ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL single_rsp cyc=%0d got=%b", c, bus.rsp_vld_r); end
            checks++;
            if (int'(bus.inflight_r) !== ((c >= 4 && c <= 8) ? 1 : 0)) begin failures++; $display("FAIL single_inflight cyc=%0d got=%0d", c, bus.inflight_r); end
            if (c >= 8) begin
                checks++;
                if (bus.rsp_dat_r !== W'(32'hA5)) begin failures++; $display("FAIL single_dat cyc=%0d got=%h exp=a5", c, bus.rsp_dat_r); end
            end
            next();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            drive_step('1, rand_dat());
            checks++;
            if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
            if (c < 8) begin
                checks++;
                if (bus.req_ack !== R'(1) << (c % R)) begin failures++; $display("FAIL rr_ack cyc=%0d got=%b", c, bus.req_ack); end
            end
            if (c >= N && c < N + 8) begin
                checks++;
                if (bus.rsp_vld_r !== R'(1) << ((c - N) % R)) begin failures++; $display("FAIL rr_rsp cyc=%0d got=%b", c, bus.rsp_vld_r); end
            end
            next();
        end
    endtask

    task automatic test_credit();
        logic [R-1:0] want;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive_step(4'b0010, rand_dat());
            checks++;
            if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL credit_model cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
            if (c < 8) begin
`ifdef DELAY_PIPE_SCHED_CREDIT_EN
                want = (c == 0 || c == 1 || c == 6 || c == 7) ? 4'b0010 : 4'b0000;
`else
                want = 4'b0010;
                checks++;
                if (int'(bus.inflight_r) !== (c < N ? c : N)) begin failures++; $display("FAIL credit_inflight cyc=%0d got=%0d", c, bus.inflight_r); end
`endif
                checks++;
                if (bus.req_ack !== want) begin failures++; $display("FAIL credit_ack cyc=%0d got=%b exp=%b", c, bus.req_ack, want); end
            end
            next();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive_step('1, rand_dat());
            next();
        end
        checks++;
        if (bus.inflight_r !== IW'(3)) begin failures++; $display("FAIL mid_inflight got=%0d exp=3", bus.inflight_r); end
        rst_n = 1'b0;
        bus.req_vld = '1;
        #4;
        checks++;
        if ({bus.req_ack, bus.rsp_vld_r, bus.inflight_r} !== '0) begin failures++; $display("FAIL mid_in_reset got=%h exp=0", dut_vec()); end
        next();
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < N + 3; c++) begin
            drive_step('0, rand_dat());
            checks++;
            if (bus.rsp_vld_r !== '0 || dut_vec() !== exp_vec()) begin failures++; $display("FAIL mid_no_rsp cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
            next();
        end
        drive_step('1, rand_dat());
        checks++;
        if (bus.req_ack !== 4'b0001) begin failures++; $display("FAIL mid_first_ack got=%b exp=0001", bus.req_ack); end
        next();
        for (int c = 0; c < 12; c++) begin
            drive_step(4'b1000, rand_dat());
            checks++;
            if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL mid_credit cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
            next();
        end
    endtask

    task automatic test_random();
        logic [R-1:0] v;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = R'($urandom);
            if ($urandom_range(0, 3) == 0) v = '0;
            if ($urandom_range(0, 5) == 0) v = '1;
            drive_step(v, rand_dat());
            checks++;
            if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL random cyc=%0d vld=%b got=%h exp=%h", c, v, dut_vec(), exp_vec()); end
            next();
        end
    endtask

    initial begin
        bus.req_vld = '0;
        bus.req_dat = '0;
        model_reset();
        next();
        test_reset();
        test_single();
        test_round_robin();
        test_credit();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
